l16b_load_sequencer: RTL and testbench

//  MEM-stage sequencer for the custom 16-byte loads (L16BW, L16BF), driven by the decoder's L16B code.
//  On Start it issues four single-word reads to data memory, one at a time, and packs them into a 128-bit buffer.
//  It stalls the pipeline for the whole sequence and pulses Done when the buffer is valid.

---
 rtl/l16b_load_sequencer_if.sv | 26 ++
 rtl/l16b_load_sequencer.sv | 164 ++++++++++++++++
 tb/tb_l16b_load_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l16b_load_sequencer_if.sv
// Bundle of pipeline-side and data-memory-side signals of the 16-byte load sequencer.
// The master modport is the sequencer. The slave modport is the pipeline/memory environment.
interface l16b_load_sequencer_if;
  logic         start;
  logic [1:0]   mode;
  logic [31:0]  addr;
  logic         abort;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;
  logic         stall;
  logic         done;
  logic [127:0] data;
  logic         error;

  modport master (
    input  start, mode, addr, abort, mem_rdata, mem_rvalid,
    output mem_req, mem_addr, stall, done, data, error
  );

  modport slave (
    output start, mode, addr, abort, mem_rdata, mem_rvalid,
    input  mem_req, mem_addr, stall, done, data, error
  );
endinterface

// File: rtl/l16b_load_sequencer.sv
// MEM-stage sequencer for L16BW/L16BF: issues four single-word reads, packs them into a
// 128-bit result, stalls the pipeline for the whole sequence and pulses done when complete.
module l16b_load_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  l16b_load_sequencer_if.master io_bus
);

  localparam int unsigned    TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 32'd2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [29:0]    r_base_w;
  logic           r_fmode;
  logic [1:0]     r_cnt;
  logic [TW-1:0]  r_tmo;
  logic [31:0]    r_mem_addr;
  logic [127:0]   r_data;
  logic           r_error;
  logic           r_done;

  logic           w_accept;
  logic           w_tmo_expire;
  logic           w_stall;
  logic           w_mem_req;
  logic [1:0]     w_cnt_nxt;
  logic [1:0]     w_lane;
  logic [31:0]    w_addr_nxt;

  assign w_accept     = (r_state == S_IDLE) && io_bus.start && io_bus.mode[1];
  // r_tmo counts silent cycles; this one would bring it to TIMEOUT-1
  assign w_tmo_expire = (r_tmo >= TMO_LAST);
  assign w_cnt_nxt    = r_cnt + 2'd1;
  assign w_lane       = r_fmode ? (r_base_w[1:0] + r_cnt) : r_cnt;
  assign w_addr_nxt   = r_fmode ? {r_base_w[29:2], r_base_w[1:0] + w_cnt_nxt, 2'b00}
                                : {r_base_w + {28'd0, w_cnt_nxt}, 2'b00};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_REQ;
        else          w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (io_bus.abort) w_state_nxt = S_IDLE;
        else              w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.mem_rvalid) begin
          if (io_bus.abort)         w_state_nxt = S_IDLE;
          else if (r_cnt == 2'd3)   w_state_nxt = S_DONE;
          else                      w_state_nxt = S_REQ;
        end else if (io_bus.abort) begin
          w_state_nxt = S_DRAIN;
        end else if (w_tmo_expire) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_DRAIN: begin
        if (io_bus.mem_rvalid || w_tmo_expire) w_state_nxt = S_IDLE;
        else                                   w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stall and request decode; both must react to start/abort within the cycle
  always_comb begin
    w_stall   = 1'b0;
    w_mem_req = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_accept;
      S_REQ: begin
        w_stall   = 1'b1;
        w_mem_req = !io_bus.abort;
      end
      S_WAIT:  w_stall = 1'b1;
      S_DRAIN: w_stall = 1'b1;
      S_DONE:  w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  // Sequence context, read address, result buffer and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base_w   <= 30'd0;
      r_fmode    <= 1'b0;
      r_cnt      <= 2'd0;
      r_tmo      <= '0;
      r_mem_addr <= 32'd0;
      r_data     <= 128'd0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base_w   <= io_bus.addr[31:2];
            r_fmode    <= io_bus.mode[0];
            r_cnt      <= 2'd0;
            r_tmo      <= '0;
            r_data     <= 128'd0;
            r_error    <= 1'b0;
            r_mem_addr <= {io_bus.addr[31:2], 2'b00};
          end
        end
        S_REQ: r_tmo <= '0;
        S_WAIT: begin
          if (io_bus.mem_rvalid) begin
            if (!io_bus.abort) begin
              r_data[32*w_lane +: 32] <= io_bus.mem_rdata;
              if (r_cnt != 2'd3) begin
                r_cnt      <= w_cnt_nxt;
                r_mem_addr <= w_addr_nxt;
              end
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
            if (!io_bus.abort && w_tmo_expire) r_error <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!io_bus.mem_rvalid && !w_tmo_expire) r_tmo <= r_tmo + TW'(1);
        end
        default: r_tmo <= r_tmo;
      endcase
    end
  end

  assign io_bus.mem_req  = w_mem_req;
  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.stall    = w_stall;
  assign io_bus.done     = r_done;
  assign io_bus.data     = r_data;
  assign io_bus.error    = r_error;

endmodule

// File: tb/tb_l16b_load_sequencer.sv
// Randomized bench for l16b_load_sequencer: a transaction-level model predicts addresses,
// packed data, stall window, done cycle and error for each load, plus directed corner cases.
module tb_l16b_load_sequencer;

  localparam int TMO = 6;

  logic clk;
  logic rst_n;
  l16b_load_sequencer_if bus ();

  l16b_load_sequencer #(.TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.master)
  );

  int          n_chk;
  int          n_fail;
  int          cyc;
  bit          pend;
  int          pend_due;
  logic [31:0] pend_data;
  logic [31:0] req_q [$];
  int          lat_a [4];
  int          mute_idx;
  logic [31:0] salt;
  bit          stray;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are sampled at the falling edge.
  task automatic tick(output bit o_stall, output bit o_done);
    int idx;
    if (pend && cyc == pend_due) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = pend_data;
      pend           = 1'b0;
    end else if (stray) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    @(negedge clk);
    o_stall = bus.stall;
    o_done  = bus.done;
    if (bus.mem_req) begin
      req_q.push_back(bus.mem_addr);
      idx = req_q.size() - 1;
      if (idx > 3) idx = 3;
      if (idx != mute_idx) begin
        pend      = 1'b1;
        pend_due  = cyc + lat_a[idx];
        pend_data = bus.mem_addr ^ salt;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ab_kind: 0 none, 1 abort in REQ of ab_word, 2 abort in WAIT cycle ab_k of ab_word.
  // mute >= 0: memory never answers that word. noise: 0 none, 1 random, 2 start held while busy.
  task automatic run_txn(input logic [1:0] md, input logic [31:0] ad,
                         input int l0, input int l1, input int l2, input int l3,
                         input int ab_kind, input int ab_word, input int ab_k,
                         input int mute, input int noise);
    logic [31:0]  ea [4];
    int           lane [4];
    int           r [4];
    int           c0, last, t, nw, nreq, ab_cyc, busy_end;
    logic [127:0] ed;
    bit           normal, st, dn;
    lat_a[0] = l0; lat_a[1] = l1; lat_a[2] = l2; lat_a[3] = l3;
    mute_idx = mute;
    req_q.delete();
    pend = 1'b0;
    c0 = cyc;
    t  = c0 + 1;
    for (int i = 0; i < 4; i++) begin
      r[i] = t;
      t    = t + 1 + lat_a[i];
      if (md[0]) begin
        lane[i] = (int'(ad[3:2]) + i) % 4;
        ea[i]   = (ad & 32'hFFFF_FFF0) + 32'(4 * lane[i]);
      end else begin
        lane[i] = i;
        ea[i]   = (ad & 32'hFFFF_FFFC) + 32'(4 * i);
      end
    end
    normal = (ab_kind == 0) && (mute < 0);
    ab_cyc = -1;
    if (ab_kind == 1) begin
      ab_cyc = r[ab_word]; last = r[ab_word]; nw = ab_word; nreq = ab_word;
    end else if (ab_kind == 2) begin
      ab_cyc = r[ab_word] + ab_k; last = r[ab_word] + lat_a[ab_word]; nw = ab_word; nreq = ab_word + 1;
    end else if (mute >= 0) begin
      last = r[mute] + TMO - 1; nw = mute; nreq = mute + 1;
    end else begin
      last = r[3] + lat_a[3]; nw = 4; nreq = 4;
    end
    busy_end = normal ? last + 1 : last;
    ed = 128'd0;
    for (int i = 0; i < nw; i++) ed[32*lane[i] +: 32] = ea[i] ^ salt;

    while (cyc <= last + 2) begin
      if (cyc == c0) begin
        bus.start = 1'b1; bus.mode = md; bus.addr = ad;
      end else if (noise != 0 && cyc <= busy_end && (noise == 2 || $urandom_range(1, 0) == 1)) begin
        bus.start = 1'b1;
        bus.mode  = (noise == 2) ? 2'b10 : 2'($urandom);
        bus.addr  = $urandom;
      end else begin
        bus.start = 1'b0; bus.mode = 2'($urandom); bus.addr = $urandom;
      end
      bus.abort = (cyc == ab_cyc) ||
                  (noise != 0 && (cyc == c0 || (normal && cyc == last + 1)) && $urandom_range(1, 0) == 1);
      t = cyc;
      tick(st, dn);
      chk_eq("stall", 128'(st), 128'(t <= last));
      chk_eq("done", 128'(dn), 128'(normal && t == last + 1));
      if (t == c0 + 1) chk_eq("err_clr", 128'(bus.error), 128'd0);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_eq("nreq", 128'(req_q.size()), 128'(nreq));
    for (int i = 0; i < nreq && i < req_q.size(); i++) chk_eq("mem_addr", 128'(req_q[i]), 128'(ea[i]));
    chk_eq("data", bus.data, ed);
    chk_eq("error", 128'(bus.error), 128'(mute >= 0 && ab_kind == 0));
  endtask

  initial begin
    bit st, dn;
    int kind, w, k;
    int l [4];
    n_chk = 0; n_fail = 0; cyc = 0;
    pend = 1'b0; stray = 1'b0; mute_idx = -1; salt = 32'd0;
    bus.start = 1'b0; bus.mode = 2'b00; bus.addr = 32'd0; bus.abort = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk_eq("rst_mem_req", 128'(bus.mem_req), 128'd0);
    chk_eq("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk_eq("rst_stall", 128'(bus.stall), 128'd0);
    chk_eq("rst_done", 128'(bus.done), 128'd0);
    chk_eq("rst_data", bus.data, 128'd0);
    chk_eq("rst_error", 128'(bus.error), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: word load, L=1, done 9 cycles after accept
    salt = 32'd0;
    run_txn(2'b10, 32'h0000_0100, 1, 1, 1, 1, 0, 0, 0, -1, 0);
    chk_eq("t1_data", bus.data, 128'h0000010C_00000108_00000104_00000100);
    // Directed: fill load starting in lane 2, L=2
    run_txn(2'b11, 32'h0000_0208, 2, 2, 2, 2, 0, 0, 0, -1, 0);
    chk_eq("t2_data", bus.data, 128'h0000020C_00000208_00000204_00000200);
    // Directed: address wrap
    salt = 32'h1357_9BDF;
    run_txn(2'b10, 32'hFFFF_FFF8, 1, 2, 1, 3, 0, 0, 0, -1, 1);
    chk_eq("t3_wrap", 128'(req_q[2]), 128'd0);
    // Directed: abort in WAIT of word 1, response 3 cycles later, start held during drain
    run_txn(2'b10, 32'h0000_4A40, 1, 4, 1, 1, 2, 1, 1, -1, 2);
    run_txn(2'b11, 32'h0000_4A44, 1, 1, 2, 1, 0, 0, 0, -1, 1);
    // Directed: timeout on word 0, then a stray response in IDLE
    run_txn(2'b10, 32'h0000_8000, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    stray = 1'b1;
    tick(st, dn);
    stray = 1'b0;
    tick(st, dn);
    chk_eq("stray_data", bus.data, 128'd0);
    chk_eq("stray_error", 128'(bus.error), 128'd1);
    chk_eq("stray_stall", 128'(st), 128'd0);
    run_txn(2'b10, 32'h0000_8010, 1, 1, 1, 1, 0, 0, 0, -1, 0);

    // Directed: asynchronous reset while waiting on word 1
    lat_a[0] = 1; lat_a[1] = 5; lat_a[2] = 5; lat_a[3] = 5;
    mute_idx = -1; req_q.delete(); salt = 32'h5A5A_1234;
    bus.start = 1'b1; bus.mode = 2'b10; bus.addr = 32'h0000_3000;
    tick(st, dn);
    bus.start = 1'b0;
    repeat (3) tick(st, dn);
    chk_eq("pre_rst_addr", 128'(bus.mem_addr), 128'h3004);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_mem_req", 128'(bus.mem_req), 128'd0);
    chk_eq("mid_rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk_eq("mid_rst_stall", 128'(bus.stall), 128'd0);
    chk_eq("mid_rst_done", 128'(bus.done), 128'd0);
    chk_eq("mid_rst_data", bus.data, 128'd0);
    chk_eq("mid_rst_error", 128'(bus.error), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pend = 1'b0;
    cyc++;
    req_q.delete();
    // Start with a non-L16B code is ignored
    bus.start = 1'b1; bus.mode = 2'b00;
    tick(st, dn);
    chk_eq("mode00_stall", 128'(st), 128'd0);
    bus.mode = 2'b01;
    tick(st, dn);
    chk_eq("mode01_stall", 128'(st), 128'd0);
    bus.start = 1'b0;
    repeat (3) tick(st, dn);
    chk_eq("mode0x_nreq", 128'(req_q.size()), 128'd0);
    chk_eq("mode0x_done", 128'(dn), 128'd0);

    // Randomized loads, aborts and timeouts
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) l[i] = $urandom_range(TMO - 1, 1);
      kind = $urandom_range(9, 0);
      w    = $urandom_range(3, 0);
      salt = $urandom;
      if (kind < 6) begin
        run_txn({1'b1, 1'($urandom)}, $urandom, l[0], l[1], l[2], l[3], 0, 0, 0, -1, 1);
      end else if (kind < 8) begin
        run_txn({1'b1, 1'($urandom)}, $urandom, l[0], l[1], l[2], l[3], 1, w, 0, -1, 1);
      end else if (kind == 8) begin
        k = $urandom_range(l[w], 1);
        run_txn({1'b1, 1'($urandom)}, $urandom, l[0], l[1], l[2], l[3], 2, w, k, -1, 1);
      end else begin
        run_txn({1'b1, 1'($urandom)}, $urandom, l[0], l[1], l[2], l[3], 0, 0, 0, w, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
